pulse_seq_gen: RTL and testbench
================================

PULSE_SEQ_GEN -- requirements
Module: pulse_seq_gen

Interface
REQ-001 The module SHALL have parameter GAP_W, default 8, giving the width of the inter-pulse gap count.
REQ-002 Port clk, input, 1: the single clock; all state changes occur on its rising edge.
REQ-003 Port rst_n, input, 1: asynchronous, active-low reset.
REQ-004 Port start, input, 1: request to emit a sequence; sampled only in IDLE.
REQ-005 Port abort, input, 1: synchronous cancel of a running sequence.
REQ-006 Port seq, input, 8: four 2-bit symbols; slot k is seq[2k+1:2k]. Encoding: 00 = none, 01 = x1, 10 = x2, 11 = x3.
REQ-007 Port len, input, 3: number of slots to play; 0 means empty, 5-7 clamp to 4.
REQ-008 Port gap, input, GAP_W: number of idle cycles between consecutive slots.
REQ-009 Ports p_x1, p_x2 and p_x3, output, 1 each: single-cycle pulse lines that drive the x1/x2/x3 inputs of the pulse-mode sequence detector.
REQ-010 Port busy, output, 1: high while a sequence is in progress (EMIT or GAP).
REQ-011 Port done, output, 1: one-cycle pulse when a sequence completes normally.

Function
REQ-012 The FSM SHALL have four states, IDLE, EMIT, GAP and DONE, with a 2-bit slot index idx and a GAP_W-bit down-counter.
REQ-013 In IDLE, with start=1 and abort=0 sampled at edge N, the block SHALL latch seq, gap and the clamped len, and set idx=0.
REQ-014 From IDLE, the next state SHALL be EMIT at N+1, or DONE at N+1 if the latched len is 0.
REQ-015 In EMIT, exactly the pulse line selected by symbol[idx] SHALL be high for that one cycle; symbol 00 SHALL consume the slot with no line high.
REQ-016 From EMIT, if idx == len-1, the next state SHALL be DONE.
REQ-017 From EMIT otherwise, if gap == 0, the next state SHALL be EMIT with idx+1, giving back-to-back pulses.
REQ-018 From EMIT otherwise, if gap != 0, the next state SHALL be GAP with the counter loaded to gap.
REQ-019 In GAP, the counter SHALL decrement each cycle; on the cycle it equals 1, the next state SHALL be EMIT with idx+1.
REQ-020 In DONE, done=1 and busy=0 for exactly one cycle, after which the next state SHALL be IDLE.
REQ-021 Timing SHALL be as follows: first pulse at cycle N+1, slot k pulse at N+1+k*(gap+1), done at N+1+(len-1)*(gap+1)+1.
REQ-022 p_x1, p_x2 and p_x3 SHALL be mutually exclusive and glitch-free, i.e. driven from registers.
REQ-023 start outside IDLE, including in DONE, SHALL be ignored; changes to seq, len or gap while busy SHALL have no effect.
REQ-024 abort=1 sampled in EMIT or GAP SHALL force IDLE at the next edge: no further pulses and no done pulse. A pulse already being emitted in the abort cycle completes.
REQ-025 If abort and start are sampled together in IDLE, abort SHALL win and the start SHALL be discarded.
REQ-026 abort in DONE SHALL be ignored; done still pulses.

Reset
REQ-027 rst_n=0 SHALL immediately force state IDLE, idx=0, counter=0, latched registers to 0, and p_x1, p_x2, p_x3, busy and done to 0.
REQ-028 Reset mid-sequence SHALL produce no done pulse; the first start accepted after rst_n rises SHALL behave per REQ-013.

Structure
REQ-029 Package pulse_seq_pkg SHALL hold the state enum, the symbol constants SYM_NONE/SYM_X1/SYM_X2/SYM_X3, and MAX_LEN=4.
REQ-030 The gap down-counter SHALL be one sub-module, pulse_gap_cnt, with load, decrement and a last-cycle flag; everything else is flat.

Verification
REQ-031 Scenario 1: seq=8'b00_11_10_01, len=3, gap=2, start at cycle 10 -> p_x1@11, p_x2@14, p_x3@17, done@18, busy 11-17.
REQ-032 Scenario 2: seq=8'h55, len=4, gap=0, start@10 -> p_x1 high cycles 11-14, done@15.
REQ-033 Scenario 3: len=0, start@10 -> done@11, no pulses, busy never high; len=7 with seq=8'h1B -> four slots: x3, x2, x1, none.
REQ-034 Scenario 4: as scenario 1, with start re-asserted at 12 (ignored) and abort at 13 -> no pulses after 11, no done, busy low from 14.
REQ-035 Scenario 5: as scenario 1, with rst_n low asynchronously mid-cycle 14 -> all outputs 0 at once, no done; after release, a new start@20 gives p_x1@21.

Source files
------------

// File: rtl/pulse_seq_pkg.sv
// Shared types and constants for the pulse sequence generator: FSM states,
// symbol encodings, slot limit and small decode helpers.
package pulse_seq_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_GAP  = 2'd2,
    ST_DONE = 2'd3
  } state_t;

  localparam logic [1:0] SYM_NONE = 2'b00;
  localparam logic [1:0] SYM_X1   = 2'b01;
  localparam logic [1:0] SYM_X2   = 2'b10;
  localparam logic [1:0] SYM_X3   = 2'b11;

  localparam int MAX_LEN = 4;

  // Requested lengths above the slot count collapse to a full four-slot sequence.
  function automatic logic [2:0] clamp_len(input logic [2:0] l);
    return (l > 3'(MAX_LEN)) ? 3'(MAX_LEN) : l;
  endfunction

  function automatic logic [1:0] slot_sym(input logic [7:0] s, input logic [1:0] idx);
    return s[{idx, 1'b0} +: 2];
  endfunction

  // Returns {x3, x2, x1}; at most one bit is ever set.
  function automatic logic [2:0] sym_to_lines(input logic [1:0] sym);
    logic [2:0] lines;
    lines = 3'b000;
    case (sym)
      SYM_X1:  lines = 3'b001;
      SYM_X2:  lines = 3'b010;
      SYM_X3:  lines = 3'b100;
      default: lines = 3'b000;
    endcase
    return lines;
  endfunction

endpackage

// File: rtl/pulse_gap_cnt.sv
// Inter-slot gap down-counter: loads the gap length, counts down while the
// generator idles between slots and flags the final gap cycle.
module pulse_gap_cnt #(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_load,
  input  logic             i_dec,
  input  logic             i_clr,
  input  logic [GAP_W-1:0] i_val,
  output logic             o_last
);

  logic [GAP_W-1:0] r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_load) begin
      r_cnt <= i_val;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_dec && (r_cnt != '0)) begin
      r_cnt <= r_cnt - 1'b1;
    end
  end

  assign o_last = (r_cnt == GAP_W'(1));

endmodule

// File: rtl/pulse_seq_gen.sv
// Plays up to four 2-bit symbols as single-cycle pulses on x1/x2/x3 lines,
// with a programmable idle gap between slots and a done pulse at the end.
module pulse_seq_gen
  import pulse_seq_pkg::*;
#(
  parameter int GAP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [7:0]       seq,
  input  logic [2:0]       len,
  input  logic [GAP_W-1:0] gap,
  output logic             p_x1,
  output logic             p_x2,
  output logic             p_x3,
  output logic             busy,
  output logic             done
);

  state_t           r_state;
  logic [1:0]       r_idx;
  logic [7:0]       r_seq;
  logic [2:0]       r_len;
  logic [GAP_W-1:0] r_gap;
  logic [2:0]       r_lines;
  logic             r_busy;
  logic             r_done;

  logic [2:0]       w_len_in;
  logic [1:0]       w_idx_nxt;
  logic             w_last_slot;
  logic             w_gap_load;
  logic             w_gap_dec;
  logic             w_gap_clr;
  logic             w_gap_last;

  assign w_len_in    = clamp_len(len);
  assign w_idx_nxt   = r_idx + 2'd1;
  assign w_last_slot = ({1'b0, r_idx} == (r_len - 3'd1));

  assign w_gap_load = (r_state == ST_EMIT) && !abort && !w_last_slot && (r_gap != '0);
  assign w_gap_dec  = (r_state == ST_GAP);
  assign w_gap_clr  = (r_state == ST_GAP) && (abort || w_gap_last);

  pulse_gap_cnt #(
    .GAP_W (GAP_W)
  ) u_gap_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_load (w_gap_load),
    .i_dec  (w_gap_dec),
    .i_clr  (w_gap_clr),
    .i_val  (r_gap),
    .o_last (w_gap_last)
  );

  // Outputs are computed from the next state so each pulse lands in the same
  // cycle the FSM occupies EMIT, straight from a flop.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_idx   <= '0;
      r_seq   <= '0;
      r_len   <= '0;
      r_gap   <= '0;
      r_lines <= '0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_lines <= '0;
      r_done  <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start && !abort) begin
            r_seq <= seq;
            r_len <= w_len_in;
            r_gap <= gap;
            r_idx <= '0;
            if (w_len_in == 3'd0) begin
              r_state <= ST_DONE;
              r_done  <= 1'b1;
            end else begin
              r_state <= ST_EMIT;
              r_busy  <= 1'b1;
              r_lines <= sym_to_lines(seq[1:0]);
            end
          end
        end
        ST_EMIT: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_last_slot) begin
            r_state <= ST_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end else if (r_gap == '0) begin
            r_idx   <= w_idx_nxt;
            r_lines <= sym_to_lines(slot_sym(r_seq, w_idx_nxt));
          end else begin
            r_state <= ST_GAP;
          end
        end
        ST_GAP: begin
          if (abort) begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end else if (w_gap_last) begin
            r_state <= ST_EMIT;
            r_idx   <= w_idx_nxt;
            r_lines <= sym_to_lines(slot_sym(r_seq, w_idx_nxt));
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  assign p_x1 = r_lines[0];
  assign p_x2 = r_lines[1];
  assign p_x3 = r_lines[2];
  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_pulse_seq_gen.sv
// Directed bench for pulse_seq_gen: per-cycle output traces against
// hand-computed schedules for each scenario.
module tb_pulse_seq_gen;

  logic       clk;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] seq;
  logic [2:0] len;
  logic [7:0] gap;
  logic       p_x1;
  logic       p_x2;
  logic       p_x3;
  logic       busy;
  logic       done;

  int checks;
  int failures;

  // Output vector layout used throughout: {p_x3, p_x2, p_x1, busy, done}
  localparam logic [4:0] E_ZERO = 5'b00000;
  localparam logic [4:0] E_X1   = 5'b00110;
  localparam logic [4:0] E_X2   = 5'b01010;
  localparam logic [4:0] E_X3   = 5'b10010;
  localparam logic [4:0] E_BUSY = 5'b00010;
  localparam logic [4:0] E_DONE = 5'b00001;

  pulse_seq_gen #(
    .GAP_W (8)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .abort (abort),
    .seq   (seq),
    .len   (len),
    .gap   (gap),
    .p_x1  (p_x1),
    .p_x2  (p_x2),
    .p_x3  (p_x3),
    .busy  (busy),
    .done  (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply_reset();
    start = 1'b0;
    abort = 1'b0;
    seq   = 8'h00;
    len   = 3'd0;
    gap   = 8'd0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  task automatic test_reset();
    logic [4:0] obs;
    start = 1'b1;
    abort = 1'b0;
    seq   = 8'h55;
    len   = 3'd4;
    gap   = 8'd0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    obs = {p_x3, p_x2, p_x1, busy, done};
    checks++;
    if (obs !== E_ZERO) begin
      failures++;
      $display("FAIL reset_immediate got=%b exp=%b", obs, E_ZERO);
    end
    repeat (2) @(posedge clk);
    #1;
    obs = {p_x3, p_x2, p_x1, busy, done};
    checks++;
    if (obs !== E_ZERO) begin
      failures++;
      $display("FAIL reset_held_start got=%b exp=%b", obs, E_ZERO);
    end
    start = 1'b0;
  endtask

  task automatic test_basic();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    seq = 8'b00_11_10_01;
    len = 3'd3;
    gap = 8'd2;
    for (int c = 0; c <= 22; c++) begin
      start = (c == 10);
      if (c == 12) begin
        seq = 8'hFF;
        len = 3'd1;
        gap = 8'd0;
      end
      case (c)
        11:          exp = E_X1;
        12, 13:      exp = E_BUSY;
        14:          exp = E_X2;
        15, 16:      exp = E_BUSY;
        17:          exp = E_X3;
        18:          exp = E_DONE;
        default:     exp = E_ZERO;
      endcase
      obs = {p_x3, p_x2, p_x1, busy, done};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL basic c=%0d got=%b exp=%b", c, obs, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_back_to_back();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    seq = 8'h55;
    len = 3'd4;
    gap = 8'd0;
    for (int c = 0; c <= 18; c++) begin
      start = (c == 10);
      case (c)
        11, 12, 13, 14: exp = E_X1;
        15:             exp = E_DONE;
        default:        exp = E_ZERO;
      endcase
      obs = {p_x3, p_x2, p_x1, busy, done};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL back_to_back c=%0d got=%b exp=%b", c, obs, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_len_edge();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    seq = 8'hE4;
    len = 3'd0;
    gap = 8'd1;
    for (int c = 0; c <= 30; c++) begin
      start = (c == 10) || (c == 20);
      if (c == 20) begin
        seq = 8'h1B;
        len = 3'd7;
      end
      case (c)
        11:          exp = E_DONE;
        21:          exp = E_X3;
        23:          exp = E_X2;
        25:          exp = E_X1;
        22, 24, 26, 27: exp = E_BUSY;
        28:          exp = E_DONE;
        default:     exp = E_ZERO;
      endcase
      obs = {p_x3, p_x2, p_x1, busy, done};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL len_edge c=%0d got=%b exp=%b", c, obs, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_abort();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    seq = 8'b00_11_10_01;
    len = 3'd3;
    gap = 8'd2;
    for (int c = 0; c <= 26; c++) begin
      start = (c == 10) || (c == 12) || (c == 20);
      abort = (c == 13) || (c == 20);
      case (c)
        11:      exp = E_X1;
        12, 13:  exp = E_BUSY;
        default: exp = E_ZERO;
      endcase
      obs = {p_x3, p_x2, p_x1, busy, done};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL abort c=%0d got=%b exp=%b", c, obs, exp);
      end
      @(posedge clk);
      #1;
    end
    abort = 1'b0;
  endtask

  task automatic test_done_ignores_start();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    seq = 8'h02;
    len = 3'd1;
    gap = 8'd0;
    for (int c = 0; c <= 16; c++) begin
      start = (c == 10) || (c == 12);
      case (c)
        11:      exp = E_X2;
        12:      exp = E_DONE;
        default: exp = E_ZERO;
      endcase
      obs = {p_x3, p_x2, p_x1, busy, done};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL done_start c=%0d got=%b exp=%b", c, obs, exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset_mid();
    logic [4:0] obs;
    logic [4:0] exp;
    apply_reset();
    seq = 8'b00_11_10_01;
    len = 3'd3;
    gap = 8'd2;
    for (int c = 0; c <= 25; c++) begin
      start = (c == 10) || (c == 20);
      if (c == 16) rst_n = 1'b1;
      case (c)
        11, 21:          exp = E_X1;
        12, 13, 22, 23, 25: exp = E_BUSY;
        14, 24:          exp = E_X2;
        default:         exp = E_ZERO;
      endcase
      obs = {p_x3, p_x2, p_x1, busy, done};
      checks++;
      if (obs !== exp) begin
        failures++;
        $display("FAIL reset_mid c=%0d got=%b exp=%b", c, obs, exp);
      end
      if (c == 14) begin
        #2 rst_n = 1'b0;
        #1;
        obs = {p_x3, p_x2, p_x1, busy, done};
        checks++;
        if (obs !== E_ZERO) begin
          failures++;
          $display("FAIL reset_mid_async got=%b exp=%b", obs, E_ZERO);
        end
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    start    = 1'b0;
    abort    = 1'b0;
    seq      = 8'h00;
    len      = 3'd0;
    gap      = 8'd0;
    rst_n    = 1'b1;
    test_reset();
    test_basic();
    test_back_to_back();
    test_len_edge();
    test_abort();
    test_done_ignores_start();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
